uart_receive: RTL and testbench
===============================

Name: uart_receive

Overview:
- UART receiver: the counterpart of uart_transmit; deserialises 8N1 frames arriving on the RX pin (i_RX at top level).
- Runs on the 50 MHz system clock and oversamples the line, so it needs no separate baud clock.
- Presents each received byte through a valid/ready handshake to downstream logic (future redstone input loader / command parser).

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first.
- CLKS_PER_BIT, 434, i_clk cycles per bit (50 MHz / 115200); must be >= 4. Counter width is $clog2(CLKS_PER_BIT).

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  reset; asynchronous, active-low.
- i_rx  input  1  raw serial line; idle high; asynchronous to i_clk.
- i_ready  input  1  consumer accepts o_data this cycle.
- o_data  output  DATA_BITS  received byte; stable while o_valid = 1.
- o_valid  output  1  byte available; held until accepted.
- o_frame_err  output  1  one-cycle pulse on a bad stop bit.
- o_overrun  output  1  one-cycle pulse when a completed byte is dropped.

Behaviour:
- Reset (i_rst = 0, asynchronous):
  - State IDLE; all counters and the shift register cleared.
  - Synchroniser flops set to 1.
  - o_data = 0, o_valid = 0, o_frame_err = 0, o_overrun = 0.
- Input synchroniser: i_rx passes through 2 flops to give rx_s. All decisions use rx_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: when rx_s = 0, go to START and clear the bit counter.
- START: count CLKS_PER_BIT/2 cycles (integer division), then sample at mid-bit.
  - rx_s = 0: go to DATA with the counter cleared.
  - rx_s = 1: glitch; return to IDLE with no output.
- DATA:
  - Sample rx_s every CLKS_PER_BIT cycles and shift it in LSB first.
  - The bit index counts 0..DATA_BITS-1.
  - After the last bit, go to STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - rx_s = 1: frame good; go to IDLE.
  - rx_s = 0: pulse o_frame_err for 1 cycle, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s = 1, then go to IDLE. This prevents a break condition from retriggering reception.
- Output register on a good frame:
  - If o_valid = 0, or i_ready = 1 in the same cycle: load o_data and set o_valid = 1 on the next edge.
  - If o_valid = 1 and i_ready = 0: keep the old o_data, drop the new byte, pulse o_overrun for 1 cycle.
- Consumer handshake: o_valid = 1 and i_ready = 1 with no new byte completing: o_valid clears on the next edge.
- Simultaneous accept and new byte: o_valid stays 1, o_data takes the new byte, no overrun.
- Latency: o_valid rises 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles after the i_rx falling edge of the start bit (±1 for synchroniser phase).
- Reset asserted mid-frame: the partial byte is lost. After release the block waits in IDLE for a fresh falling edge.
- A line held low at reset release is treated as a start bit. Its frame then ends in a frame error and WAIT_IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one extra bit.
  - Even parity over the data bits is checked.
  - On mismatch, port o_parity_err (1 bit, output) pulses for 1 cycle and the byte is discarded. The STOP check still runs.
  - Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state and no o_parity_err port; frames are 8N1.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state enum (shared with a future uart_transmit rewrite);
  - the default CLKS_PER_BIT;
  - the DATA_BITS default.
- Sub-module sync_2ff: reusable 2-flop synchroniser with reset value parameter RST_VAL (1 here). Also reused for the switch and button inputs.

Test Plan (CLKS_PER_BIT = 16 for sim speed):
- Send 0xA5 as 8N1 with i_ready = 1 → o_valid high for 1 cycle, o_data = 0xA5, no error pulses.
- Send 0x3C then 0xC3 back to back with i_ready = 0 → o_data = 0x3C held, o_overrun pulses once at the end of the second frame, o_valid stays 1. Then raise i_ready → o_valid drops next cycle.
- 4-cycle low glitch on i_rx → FSM returns to IDLE, no o_valid, no o_frame_err.
- Send 0x55 with the stop bit forced to 0, then hold the line low for 40 bits → exactly one o_frame_err pulse, no o_valid. After the line returns high, 0x12 is received correctly.
- Assert i_rst mid-data-bit 4 of 0xFF, release, then send 0x81 → only 0x81 appears, o_valid = 1 once.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 (wrong) → o_parity_err pulses, no o_valid. With parity bit 1 → o_data = 0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and the receiver/transmitter FSM state encoding.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit inputs; RST_VAL sets the flop reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage metastability filter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_receive.sv
// Oversampling UART receiver (8N1) with a valid/ready output register.
// Define UART_RX_PARITY_EN to add an even-parity bit and the o_parity_err pulse.
module uart_receive
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = UART_DATA_BITS,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 o_parity_err,
`endif
  output logic                 o_overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_e          state_r;
  logic [CNT_W-1:0]     clk_cnt_r;
  logic [IDX_W-1:0]     bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r;
  logic                 frame_err_r;
  logic                 overrun_r;
  logic                 parity_bad_r;
  logic                 rx_s;

`ifdef UART_RX_PARITY_EN
  logic                 parity_err_r;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`endif

  sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .clk   (i_clk),
    .rst_n (i_rst),
    .d     (i_rx),
    .q     (rx_s)
  );

  // Frame FSM, bit timing, and output register with handshake/overrun handling
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r      <= ST_IDLE;
      clk_cnt_r    <= '0;
      bit_idx_r    <= '0;
      shift_r      <= '0;
      data_r       <= '0;
      valid_r      <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
      parity_bad_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      // A consumer accept clears valid unless a new good byte reloads it below
      if (valid_r && i_ready) begin
        valid_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (!rx_s) begin
            state_r   <= ST_START;
            clk_cnt_r <= '0;
            bit_idx_r <= '0;
          end
        end
        ST_START: begin
          if (clk_cnt_r == HALF_CNT) begin
            clk_cnt_r    <= '0;
            bit_idx_r    <= '0;
            parity_bad_r <= 1'b0;
            state_r      <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            clk_cnt_r <= clk_cnt_r + 1'b1;
          end
        end
        ST_DATA: begin
          if (clk_cnt_r == LAST_CNT) begin
            clk_cnt_r <= '0;
            shift_r   <= {rx_s, shift_r[DATA_BITS-1:1]};
            if (bit_idx_r == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              state_r <= ST_PARITY;
`else
              state_r <= ST_STOP;
`endif
            end else begin
              bit_idx_r <= bit_idx_r + 1'b1;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + 1'b1;
          end
        end
        ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (clk_cnt_r == LAST_CNT) begin
            clk_cnt_r    <= '0;
            parity_bad_r <= (rx_s != even_parity(shift_r));
            parity_err_r <= (rx_s != even_parity(shift_r));
            state_r      <= ST_STOP;
          end else begin
            clk_cnt_r <= clk_cnt_r + 1'b1;
          end
`else
          state_r <= ST_IDLE;
`endif
        end
        ST_STOP: begin
          if (clk_cnt_r == LAST_CNT) begin
            clk_cnt_r <= '0;
            if (rx_s) begin
              state_r <= ST_IDLE;
              if (!parity_bad_r) begin
                if (!valid_r || i_ready) begin
                  data_r  <= shift_r;
                  valid_r <= 1'b1;
                end else begin
                  overrun_r <= 1'b1;
                end
              end
            end else begin
              frame_err_r <= 1'b1;
              state_r     <= ST_WAIT_IDLE;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + 1'b1;
          end
        end
        // A held-low (break) line must go high before a new start bit is accepted
        ST_WAIT_IDLE: begin
          if (rx_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_data      = data_r;
  assign o_valid     = valid_r;
  assign o_frame_err = frame_err_r;
  assign o_overrun   = overrun_r;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_receive.sv
// Directed self-checking bench for uart_receive at 16 clocks per bit.
// Honours UART_RX_PARITY_EN: frames then carry an even-parity bit and parity tests run.
module tb_uart_receive;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int LAT = 2 + CPB / 2 + (8 + 1) * CPB + 1 + (PAR_EN ? CPB : 0);

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_rx;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_parity_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int vcyc = 0, ferr = 0, ovr = 0, perr = 0, rise_cyc = 0;
  logic [7:0] last_data = 8'h00;
  logic prev_v = 1'b0;
  int vb, fb, ob, pb;

  always #10 clk = ~clk;

  uart_receive #(.DATA_BITS(8), .CLKS_PER_BIT(CPB)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_rx        (i_rx),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
`ifdef UART_RX_PARITY_EN
    .o_parity_err(o_parity_err),
`endif
    .o_overrun   (o_overrun)
  );
`ifndef UART_RX_PARITY_EN
  assign o_parity_err = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor sampled away from the active edge
  always @(negedge clk) begin
    if (o_valid) begin
      vcyc <= vcyc + 1;
      last_data <= o_data;
    end
    if (o_valid && !prev_v) rise_cyc <= cyc;
    prev_v <= o_valid;
    if (o_frame_err) ferr <= ferr + 1;
    if (o_overrun) ovr <= ovr + 1;
    if (o_parity_err) perr <= perr + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    @(negedge clk);
    vb = vcyc; fb = ferr; ob = ovr; pb = perr;
  endtask

  task automatic bit_time(input logic v);
    i_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    i_rx = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    if (PAR_EN) bit_time(par);
    bit_time(stop);
    i_rx = 1'b1;
  endtask

  initial begin
    int lat;
    i_rst = 1'b0; i_rx = 1'b1; i_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_data", {24'h0, o_data}, 32'h0);
    check("rst_valid", {31'h0, o_valid}, 32'h0);
    check("rst_ferr", {31'h0, o_frame_err}, 32'h0);
    check("rst_ovr", {31'h0, o_overrun}, 32'h0);
    i_rst = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    // Single byte with consumer ready
    i_ready = 1'b1;
    snap();
    send_frame(8'hA5, ^8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    lat = rise_cyc - start_cyc;
    check("a5_vcyc", vcyc - vb, 32'd1);
    check("a5_data", {24'h0, last_data}, 32'hA5);
    check("a5_ferr", ferr - fb, 32'd0);
    check("a5_ovr", ovr - ob, 32'd0);
    check("a5_latency_ok", {31'h0, (lat >= LAT - 1) && (lat <= LAT + 1)}, 32'd1);
    $display("latency %0d cycles (nominal %0d)", lat, LAT);

    // Back-to-back frames with consumer stalled
    i_ready = 1'b0;
    snap();
    send_frame(8'h3C, ^8'h3C, 1'b1);
    send_frame(8'hC3, ^8'hC3, 1'b1);
    repeat (4) @(negedge clk);
    check("ovr_valid", {31'h0, o_valid}, 32'd1);
    check("ovr_data", {24'h0, o_data}, 32'h3C);
    check("ovr_count", ovr - ob, 32'd1);
    i_ready = 1'b1;
    @(negedge clk);
    check("accept_valid", {31'h0, o_valid}, 32'd0);

    // Short low glitch
    snap();
    i_rx = 1'b0;
    repeat (4) @(negedge clk);
    i_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_vcyc", vcyc - vb, 32'd0);
    check("glitch_ferr", ferr - fb, 32'd0);

    // Bad stop bit followed by a long break, then recovery
    snap();
    send_frame(8'h55, ^8'h55, 1'b0);
    i_rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    check("brk_ferr", ferr - fb, 32'd1);
    check("brk_vcyc", vcyc - vb, 32'd0);
    i_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h12, ^8'h12, 1'b1);
    repeat (4) @(negedge clk);
    check("brk_rx12_data", {24'h0, last_data}, 32'h12);
    check("brk_rx12_vcyc", vcyc - vb, 32'd1);

    // Reset in the middle of data bit 4 of 0xFF
    i_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) bit_time(1'b1);
    i_rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    i_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_data", {24'h0, o_data}, 32'h0);
    i_rst = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    snap();
    send_frame(8'h81, ^8'h81, 1'b1);
    repeat (4) @(negedge clk);
    check("midrst_vcyc", vcyc - vb, 32'd1);
    check("midrst_data81", {24'h0, last_data}, 32'h81);
    check("midrst_ferr", ferr - fb, 32'd0);

`ifdef UART_RX_PARITY_EN
    // Wrong then correct even parity for 0x07
    repeat (CPB) @(negedge clk);
    snap();
    send_frame(8'h07, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("par_bad_perr", perr - pb, 32'd1);
    check("par_bad_vcyc", vcyc - vb, 32'd0);
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("par_ok_perr", perr - pb, 32'd0);
    check("par_ok_vcyc", vcyc - vb, 32'd1);
    check("par_ok_data", {24'h0, last_data}, 32'h07);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
